// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter and the sync FIFO instances it feeds.
package fifo_arb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int unsigned FIFO_WIDTH         = 8;
  localparam int unsigned FIFO_DEPTH         = 16;
  localparam int unsigned FIFO_POINTER_WIDTH = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit after last_idx, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[IDX_W'((32'(last_idx) + k) % NUM_REQ)]) begin
        found = 1'b1;
        idx   = IDX_W'((32'(last_idx) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one sync FIFO write port among NUM_REQ producers.
// Optional statistics counters are enabled with `define FIFO_WR_ARBITER_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned WIDTH         = FIFO_WIDTH,
  parameter int unsigned DEPTH         = FIFO_DEPTH,
  parameter int unsigned POINTER_WIDTH = FIFO_POINTER_WIDTH,
  parameter int unsigned MAX_BURST     = 4,
  parameter int unsigned IDX_W         = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wdata,
  input  logic                     fifo_full,
  input  logic                     fifo_rd_en,
  input  logic                     fifo_empty,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     busy,
  output logic [POINTER_WIDTH:0]   occupancy
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  output logic [15:0]              stall_cnt,
  output logic [NUM_REQ*16-1:0]    grant_cnt
`endif
);

  localparam int unsigned       CW        = POINTER_WIDTH + 1;
  localparam logic [CW-1:0]     DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0]     LAST_BEAT = CW'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]  LAST_REQ  = IDX_W'(NUM_REQ - 1);

  arb_state_e       state, state_n;
  logic [IDX_W-1:0] last_idx, last_idx_n, grant_idx_n, pick_idx;
  logic [CW-1:0]    burst_cnt, burst_cnt_n;
  logic             pick_found, space, owner_req, wr, rd;
  logic [WIDTH-1:0] owner_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req      (req),
    .last_idx (last_idx),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  always_comb begin
    owner_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) owner_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Local count guards the cycle where the FIFO's registered full flag still lags a write.
  assign space     = (occupancy < DEPTH_C) && !fifo_full;
  assign owner_req = req[grant_idx];
  assign rd        = fifo_rd_en && !fifo_empty;

  always_comb begin
    state_n     = state;
    grant_idx_n = grant_idx;
    last_idx_n  = last_idx;
    burst_cnt_n = burst_cnt;
    wr          = 1'b0;
    case (state)
      ARB: begin
        if (pick_found) begin
          grant_idx_n = pick_idx;
          burst_cnt_n = '0;
          state_n     = BURST;
        end
      end
      BURST: begin
        if (!owner_req) begin
          state_n    = ARB;
          last_idx_n = grant_idx;
        end else if (space) begin
          wr          = 1'b1;
          burst_cnt_n = burst_cnt + CW'(1);
          if (burst_cnt == LAST_BEAT) begin
            state_n    = ARB;
            last_idx_n = grant_idx;
          end
        end
      end
      default: state_n = ARB;
    endcase
  end

  always_comb begin
    ack = '0;
    if (wr) ack[grant_idx] = 1'b1;
  end

  assign fifo_wr_en = wr;
  assign fifo_wdata = wr ? owner_data : '0;
  assign busy       = (state == BURST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ARB;
      grant_idx <= '0;
      last_idx  <= LAST_REQ;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      grant_idx <= grant_idx_n;
      last_idx  <= last_idx_n;
      burst_cnt <= burst_cnt_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy <= '0;
    end else if (wr && !rd && occupancy != DEPTH_C) begin
      occupancy <= occupancy + CW'(1);
    end else if (rd && !wr && occupancy != '0) begin
      occupancy <= occupancy - CW'(1);
    end
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (busy && owner_req && !space && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (state == ARB && pick_found && pick_idx == IDX_W'(i) &&
            grant_cnt[i*16 +: 16] != 16'hFFFF) begin
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter with a queue-based FIFO model on the write port.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ = 4, WIDTH = 8, DEPTH = 16, PW = 4, MAX_BURST = 4, IDX_W = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ*WIDTH-1:0] req_data = '0;
  logic [NUM_REQ-1:0]       ack;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_wdata;
  logic                     fifo_full;
  logic                     fifo_rd_en;
  logic                     fifo_empty = 1'b1;
  logic                     fifo_full_base = 1'b0;
  logic                     glitch = 1'b0;
  logic                     rd_reg = 1'b0;
  logic [IDX_W-1:0]         grant_idx;
  logic                     busy;
  logic [PW:0]              occupancy;
`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [15:0]              stall_cnt;
  logic [NUM_REQ*16-1:0]    grant_cnt;
`endif

  int rd_mode = 0;   // 0 none, 1 random, 2 always, 3 read alongside every write
  bit glitch_en = 1'b0;
  int errors = 0, checks = 0, cyc = 0, wr_total = 0;

  logic [WIDTH-1:0] src_q[NUM_REQ][$];
  logic [WIDTH-1:0] exp_q[NUM_REQ][$];
  logic [WIDTH-1:0] fq[$];
  int grant_log[$];
  int wr_cyc[$];

  logic [NUM_REQ-1:0] cap_ack = '0;
  logic               cap_wr = 1'b0, cap_rd = 1'b0;
  logic [WIDTH-1:0]   cap_wdata = '0;

  assign fifo_full  = fifo_full_base | glitch;
  assign fifo_rd_en = (rd_mode == 3) ? fifo_wr_en : rd_reg;

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .DEPTH(DEPTH),
    .POINTER_WIDTH(PW), .MAX_BURST(MAX_BURST), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
    .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty), .grant_idx(grant_idx),
    .busy(busy), .occupancy(occupancy)
`ifdef FIFO_WR_ARBITER_STATS_EN
    , .stall_cnt(stall_cnt), .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_next(int last, logic [NUM_REQ-1:0] r);
    logic [NUM_REQ-1:0] t;
    for (int k = 1; k <= NUM_REQ; k++) begin
      t = r >> ((last + k) % NUM_REQ);
      if (t[0]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NUM_REQ; i++) s += src_q[i].size();
    return s;
  endfunction

  // Downstream FIFO: writes/reads captured mid-cycle are applied at the clock edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fq.delete();
      fifo_full_base <= 1'b0;
      fifo_empty     <= 1'b1;
    end else begin
      if (cap_rd && fq.size() > 0) void'(fq.pop_front());
      if (cap_wr && fq.size() < DEPTH) fq.push_back(cap_wdata);
      fifo_full_base <= (fq.size() == DEPTH);
      fifo_empty     <= (fq.size() == 0);
    end
  end

  initial begin : monitor
    int m_last, m_cnt, p_owner, eo, s_occ;
    logic p_valid, p_busy, p_wr, exp_wr, exp_busy;
    logic s_wr, s_busy, s_full, s_rd, s_empty;
    logic [NUM_REQ-1:0] p_req, s_req, s_ack;
    logic [WIDTH-1:0] s_wdata;
    logic [IDX_W-1:0] s_gidx;
    m_last = NUM_REQ - 1; m_cnt = 0; p_owner = 0;
    p_valid = 1'b0; p_busy = 1'b0; p_wr = 1'b0; p_req = '0;
    forever begin
      @(negedge clk); #1;
      cyc++;
      s_req = req; s_ack = ack; s_wr = fifo_wr_en; s_wdata = fifo_wdata;
      s_busy = busy; s_gidx = grant_idx; s_occ = int'(occupancy);
      s_full = fifo_full; s_rd = fifo_rd_en; s_empty = fifo_empty;
      cap_ack = s_ack; cap_wr = s_wr; cap_wdata = s_wdata; cap_rd = s_rd && !s_empty;
      if (!reset) begin
        m_last = NUM_REQ - 1; m_cnt = 0; p_valid = 1'b0;
      end else begin
        chk("occupancy", s_occ, fq.size());
        if (p_valid) begin
          exp_busy = p_busy ? (p_req[p_owner] && !(p_wr && m_cnt == MAX_BURST)) : (p_req != '0);
          chk("busy", s_busy, exp_busy);
          if (p_busy && !s_busy) m_last = p_owner;
          if (!p_busy && s_busy) begin
            eo = rr_next(m_last, p_req);
            chk("grant_idx", s_gidx, eo);
            grant_log.push_back(int'(s_gidx));
            m_cnt = 0;
          end
        end
        exp_wr = s_busy && s_req[s_gidx] && (fq.size() < DEPTH) && !s_full;
        chk("wr_en", s_wr, exp_wr);
        if (s_wr) begin
          wr_total++;
          wr_cyc.push_back(cyc);
          m_cnt++;
          chk("ack", s_ack, 1 << s_gidx);
          chk("sb_pending", exp_q[s_gidx].size() > 0, 1);
          if (exp_q[s_gidx].size() > 0) chk("wdata", s_wdata, exp_q[s_gidx].pop_front());
        end else begin
          chk("ack_idle", s_ack, 0);
        end
        p_valid = 1'b1; p_busy = s_busy; p_wr = s_wr; p_req = s_req; p_owner = s_gidx;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cap_ack[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      req[i] = (src_q[i].size() > 0);
      req_data[i*WIDTH +: WIDTH] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
    rd_reg = (rd_mode == 1) ? 1'($urandom_range(0, 1)) : (rd_mode == 2);
    glitch = glitch_en && ($urandom_range(0, 9) == 0);
  endtask

  task automatic push_words(int i, int n);
    logic [WIDTH-1:0] d;
    for (int k = 0; k < n; k++) begin
      d = WIDTH'($urandom);
      src_q[i].push_back(d);
      exp_q[i].push_back(d);
    end
  endtask

  task automatic do_reset(bit flush);
    @(posedge clk); #1 reset = 1'b0; #1;
    chk("rst_ack", ack, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_gidx", grant_idx, 0);
    chk("rst_wdata", fifo_wdata, 0);
    if (flush) begin
      for (int i = 0; i < NUM_REQ; i++) begin src_q[i].delete(); exp_q[i].delete(); end
    end
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic drain(int max);
    int n = 0;
    while (pending() != 0 && n < max) begin tick(); n++; end
    chk("drain_timeout", pending(), 0);
    repeat (3) tick();
  endtask

  initial begin : driver
    int base, n, k, tot;
    do_reset(1'b1);

    // Single requester: 4 writes, one bubble, 2 writes.
    rd_mode = 0;
    push_words(2, 6);
    wr_cyc.delete();
    drain(60);
    #2;
    chk("s1_occ", occupancy, 6);
    chk("s1_nwr", wr_cyc.size(), 6);
    if (wr_cyc.size() == 6) begin
      chk("s1_burst_span", wr_cyc[3] - wr_cyc[0], 3);
      chk("s1_bubble", wr_cyc[4] - wr_cyc[3], 2);
      chk("s1_tail", wr_cyc[5] - wr_cyc[4], 1);
    end

    // All requesting: grants rotate 0,1,2,3,0.
    do_reset(1'b1);
    rd_mode = 2;
    for (int i = 0; i < NUM_REQ; i++) push_words(i, 8);
    grant_log.delete();
    repeat (26) tick();
    chk("s2_ngrants", grant_log.size() >= 5, 1);
    for (int g = 0; g < 5; g++) if (g < grant_log.size()) chk("s2_grant_order", grant_log[g], g % NUM_REQ);
    drain(200);

    // No reads, 20 words: FIFO fills to DEPTH and the grant is held.
    do_reset(1'b1);
    rd_mode = 0;
    base = wr_total;
    push_words(1, 20);
    repeat (40) tick();
    #2;
    chk("s3_writes", wr_total - base, 16);
    chk("s3_occ", occupancy, 16);
    chk("s3_busy", busy, 1);
    chk("s3_gidx", grant_idx, 1);
    chk("s3_wr_en", fifo_wr_en, 0);
    chk("s3_left", src_q[1].size(), 4);

    // One read at full: exactly one more write.
    base = wr_total;
    rd_mode = 2; tick(); rd_mode = 0; #2;
    chk("s4_occ0", occupancy, 16);
    tick(); #2;
    chk("s4_occ1", occupancy, 15);
    chk("s4_wr1", fifo_wr_en, 1);
    tick(); #2;
    chk("s4_occ2", occupancy, 16);
    chk("s4_wr2", fifo_wr_en, 0);
    chk("s4_writes", wr_total - base, 1);
    chk("s4_left", src_q[1].size(), 3);

    // Occupancy 8 with a read alongside every write; then reads on an empty FIFO.
    do_reset(1'b1);
    rd_mode = 0;
    push_words(0, 8);
    drain(40);
    #2 chk("s5_fill", occupancy, 8);
    base = wr_total;
    push_words(0, 12);
    rd_mode = 3;
    repeat (24) tick();
    #2;
    chk("s5_occ", occupancy, 8);
    chk("s5_writes", wr_total - base, 12);
    do_reset(1'b1);
    rd_mode = 2;
    repeat (5) tick();
    #2 chk("s5_empty_occ", occupancy, 0);
    rd_mode = 0;

    // Reset after 2 of 4 words of a burst; stream resumes, arbitration restarts at 0.
    do_reset(1'b1);
    push_words(2, 6);
    n = 0; k = 0;
    while (n < 2 && k < 20) begin
      tick(); #2;
      if (ack[2]) n++;
      k++;
    end
    chk("s6_acks", n, 2);
    @(posedge clk); #1;
    chk("s6_pre_ack", ack[2], 1);
    reset = 1'b0; #1;
    chk("s6_ack", ack, 0);
    chk("s6_wr_en", fifo_wr_en, 0);
    chk("s6_busy", busy, 0);
    chk("s6_occ", occupancy, 0);
    tick(); tick();
    chk("s6_left", src_q[2].size(), 4);
    push_words(0, 4); push_words(1, 4); push_words(3, 4);
    grant_log.delete();
    rd_mode = 2;
    tick();
    reset = 1'b1;
    drain(200);
    chk("s6_first_grant_seen", grant_log.size() > 0, 1);
    if (grant_log.size() > 0) chk("s6_first_grant", grant_log[0], 0);

    // Random traffic with random reads and spurious full.
    do_reset(1'b1);
    rd_mode = 1;
    glitch_en = 1'b1;
    repeat (1500) begin
      for (int i = 0; i < NUM_REQ; i++)
        if ($urandom_range(0, 3) == 0 && src_q[i].size() < 6) push_words(i, 1);
      tick();
    end
    glitch_en = 1'b0;
    rd_mode = 2;
    drain(300);
    tot = 0;
    for (int i = 0; i < NUM_REQ; i++) tot += exp_q[i].size();
    chk("sb_leftover", tot, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
